// File: rtl/uart_mux_link.sv
// Host-side endpoint of the UART FIFO port: round-robin multiplexes channel bytes into
// 2-byte tagged records on transmit and demultiplexes received records per channel.
module uart_mux_link #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CH_BITS   = 2,
    parameter logic [3:0]  HDR_TAG   = 4'hA
) (
    input  logic                                 clk,
    input  logic                                 reset,
    output logic [DATA_BITS-1:0]                 uart_tx_data,
    output logic                                 uart_write,
    input  logic                                 uart_tx_full,
    input  logic [DATA_BITS-1:0]                 uart_rx_data,
    output logic                                 uart_read,
    input  logic                                 uart_rx_empty,
    input  logic [(2**CH_BITS)*DATA_BITS-1:0]    ch_tx_data,
    input  logic [2**CH_BITS-1:0]                ch_tx_valid,
    output logic [2**CH_BITS-1:0]                ch_tx_ready,
    output logic [DATA_BITS-1:0]                 ch_rx_data,
    output logic [2**CH_BITS-1:0]                ch_rx_valid,
    input  logic [2**CH_BITS-1:0]                ch_rx_ready,
    output logic                                 sync_error,
    output logic [7:0]                           err_count
);

    localparam int unsigned CHANNELS = 2**CH_BITS;
    localparam int unsigned PAD_BITS = DATA_BITS - 4 - CH_BITS;

    typedef enum logic [1:0] {T_IDLE, T_HDR, T_DAT} tx_state_t;
    typedef enum logic [1:0] {R_HDR, R_DAT, R_OUT} rx_state_t;

    tx_state_t              tx_state, tx_next;
    rx_state_t              rx_state, rx_next;
    logic [CH_BITS-1:0]     last_ch, tx_ch, rx_ch;
    logic [CH_BITS-1:0]     grant_ch, cand;
    logic                   grant_found;
    logic [DATA_BITS-1:0]   tx_hold, grant_byte;
    logic                   hdr_ok;
    logic                   rx_bad;

    // Search last+1 upward with wrap; the first valid channel found wins.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            cand = last_ch + CH_BITS'(i);
            if (!grant_found && ch_tx_valid[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    assign grant_byte = ch_tx_data[grant_ch*DATA_BITS +: DATA_BITS];

    always_comb begin
        tx_next     = tx_state;
        ch_tx_ready = '0;
        uart_write  = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (grant_found) begin
                    ch_tx_ready[grant_ch] = 1'b1;
                    tx_next               = T_HDR;
                end
            end
            T_HDR: begin
                uart_write = ~uart_tx_full;
                if (!uart_tx_full) tx_next = T_DAT;
            end
            T_DAT: begin
                uart_write = ~uart_tx_full;
                if (!uart_tx_full) tx_next = T_IDLE;
            end
            default: tx_next = T_IDLE;
        endcase
    end

    // uart_tx_data is loaded one step ahead so it already shows the header on entry to T_HDR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state     <= T_IDLE;
            last_ch      <= CH_BITS'(CHANNELS - 1);
            tx_ch        <= '0;
            tx_hold      <= '0;
            uart_tx_data <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == T_IDLE && grant_found) begin
                tx_ch        <= grant_ch;
                tx_hold      <= grant_byte;
                uart_tx_data <= {HDR_TAG, {PAD_BITS{1'b0}}, grant_ch};
            end
            if (tx_state == T_HDR && !uart_tx_full) uart_tx_data <= tx_hold;
            if (tx_state == T_DAT && !uart_tx_full) last_ch <= tx_ch;
        end
    end

    assign hdr_ok = (uart_rx_data[DATA_BITS-1 -: 4] == HDR_TAG) &&
                    (uart_rx_data[DATA_BITS-5:CH_BITS] == '0);
    assign rx_bad = (rx_state == R_HDR) && !uart_rx_empty && !hdr_ok;

    always_comb begin
        rx_next     = rx_state;
        uart_read   = 1'b0;
        ch_rx_valid = '0;
        case (rx_state)
            R_HDR: begin
                uart_read = ~uart_rx_empty;
                if (!uart_rx_empty && hdr_ok) rx_next = R_DAT;
            end
            R_DAT: begin
                uart_read = ~uart_rx_empty;
                if (!uart_rx_empty) rx_next = R_OUT;
            end
            R_OUT: begin
                ch_rx_valid[rx_ch] = 1'b1;
                if (ch_rx_ready[rx_ch]) rx_next = R_HDR;
            end
            default: rx_next = R_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state   <= R_HDR;
            rx_ch      <= '0;
            ch_rx_data <= '0;
            sync_error <= 1'b0;
            err_count  <= '0;
        end else begin
            rx_state   <= rx_next;
            sync_error <= rx_bad;
            if (rx_bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (rx_state == R_HDR && !uart_rx_empty && hdr_ok) rx_ch <= uart_rx_data[CH_BITS-1:0];
            if (rx_state == R_DAT && !uart_rx_empty) ch_rx_data <= uart_rx_data;
        end
    end

endmodule

// File: tb/tb_uart_mux_link.sv
// Scoreboard bench for uart_mux_link: a modelled RX FIFO feeds the DUT, monitors pop
// expected TX writes and RX deliveries from queues filled when stimulus is driven.
module tb_uart_mux_link;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  uart_tx_data;
    logic        uart_write;
    logic        uart_tx_full;
    logic [7:0]  uart_rx_data;
    logic        uart_read;
    logic        uart_rx_empty;
    logic [31:0] ch_tx_data;
    logic [3:0]  ch_tx_valid;
    logic [3:0]  ch_tx_ready;
    logic [7:0]  ch_rx_data;
    logic [3:0]  ch_rx_valid;
    logic [3:0]  ch_rx_ready;
    logic        sync_error;
    logic [7:0]  err_count;

    typedef struct {
        int         ch;
        logic [7:0] data;
    } rx_rec_t;

    int         checks   = 0;
    int         failures = 0;
    int         write_cnt = 0;
    int         sync_cnt  = 0;
    logic [7:0] tx_exp[$];
    rx_rec_t    rx_exp[$];
    logic [3:0] grant_log[$];

    // RX FIFO model: bench owns the write pointer, the pop process owns the read pointer.
    logic [7:0] rx_mem[512];
    int         rx_wr = 0;
    int         rx_rd = 0;

    assign uart_rx_empty = (rx_rd == rx_wr);
    assign uart_rx_data  = rx_mem[rx_rd % 512];

    always #5 clk = ~clk;

    uart_mux_link #(.DATA_BITS(8), .CH_BITS(2), .HDR_TAG(4'hA)) dut (
        .clk(clk), .reset(reset),
        .uart_tx_data(uart_tx_data), .uart_write(uart_write), .uart_tx_full(uart_tx_full),
        .uart_rx_data(uart_rx_data), .uart_read(uart_read), .uart_rx_empty(uart_rx_empty),
        .ch_tx_data(ch_tx_data), .ch_tx_valid(ch_tx_valid), .ch_tx_ready(ch_tx_ready),
        .ch_rx_data(ch_rx_data), .ch_rx_valid(ch_rx_valid), .ch_rx_ready(ch_rx_ready),
        .sync_error(sync_error), .err_count(err_count)
    );

    always @(posedge clk) begin
        if (uart_read === 1'b1) begin
            #1;
            rx_rd = rx_rd + 1;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        rx_rec_t    r;
        if (uart_write === 1'b1) begin
            write_cnt++;
            checks++;
            if (tx_exp.size() == 0) begin
                failures++;
                $display("FAIL tx_write: got %h, expected no write", uart_tx_data);
            end else begin
                e = tx_exp.pop_front();
                if (uart_tx_data !== e) begin
                    failures++;
                    $display("FAIL tx_byte: got %h, expected %h", uart_tx_data, e);
                end
            end
        end
        if (ch_tx_ready != 4'b0) grant_log.push_back(ch_tx_ready);
        if (sync_error === 1'b1) sync_cnt++;
        if ((ch_rx_valid & ch_rx_ready) != 4'b0) begin
            checks++;
            if (rx_exp.size() == 0) begin
                failures++;
                $display("FAIL rx_deliver: got valid=%b data=%h, expected none", ch_rx_valid, ch_rx_data);
            end else begin
                r = rx_exp.pop_front();
                if ({ch_rx_valid, ch_rx_data} !== {4'(1 << r.ch), r.data}) begin
                    failures++;
                    $display("FAIL rx_deliver: got valid=%b data=%h, expected valid=%b data=%h",
                             ch_rx_valid, ch_rx_data, 4'(1 << r.ch), r.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_mem[rx_wr % 512] = b;
        rx_wr = rx_wr + 1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        ch_tx_valid  = '0;
        ch_rx_ready  = '0;
        uart_tx_full = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        ch_tx_valid  = '0;
        ch_tx_data   = '0;
        ch_rx_ready  = '0;
        uart_tx_full = 1'b0;
        #1;
        checks++;
        if ({uart_tx_data, uart_write, uart_read, ch_tx_ready, ch_rx_data, ch_rx_valid,
             sync_error, err_count} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs: got tx=%h wr=%b rd=%b rdy=%b rxd=%h rxv=%b se=%b ec=%0d, expected all 0",
                     uart_tx_data, uart_write, uart_read, ch_tx_ready, ch_rx_data, ch_rx_valid,
                     sync_error, err_count);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        ch_tx_data[23:16] = 8'h5A;
        ch_tx_valid       = 4'b0100;
        tx_exp.push_back(8'hA2);
        tx_exp.push_back(8'h5A);
        #1;
        checks++;
        if (ch_tx_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_grant: got %b, expected 0100", ch_tx_ready);
        end
        tick();
        ch_tx_valid = '0;
        checks++;
        if ({uart_write, uart_tx_data} !== {1'b1, 8'hA2}) begin
            failures++;
            $display("FAIL single_hdr: got wr=%b data=%h, expected wr=1 data=a2", uart_write, uart_tx_data);
        end
        tick();
        checks++;
        if ({uart_write, uart_tx_data} !== {1'b1, 8'h5A}) begin
            failures++;
            $display("FAIL single_dat: got wr=%b data=%h, expected wr=1 data=5a", uart_write, uart_tx_data);
        end
        tick();
        checks++;
        if ({uart_write, uart_tx_data, tx_exp.size()} !== {1'b0, 8'h5A, 32'd0}) begin
            failures++;
            $display("FAIL single_idle: got wr=%b data=%h pending=%0d, expected wr=0 data=5a pending=0",
                     uart_write, uart_tx_data, tx_exp.size());
        end
    endtask

    task automatic test_round_robin();
        int w0;
        do_reset();
        grant_log.delete();
        w0         = write_cnt;
        ch_tx_data = {8'h13, 8'h12, 8'h11, 8'h10};
        ch_tx_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tx_exp.push_back(8'hA0 | 8'(k % 4));
            tx_exp.push_back(8'h10 + 8'(k % 4));
        end
        for (int k = 0; k < 12; k++) tick();
        checks++;
        if (write_cnt - w0 !== 8) begin
            failures++;
            $display("FAIL rr_writes_per_round: got %0d, expected 8", write_cnt - w0);
        end
        tick();
        ch_tx_valid = '0;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (write_cnt - w0 !== 10 || grant_log.size() !== 5) begin
            failures++;
            $display("FAIL rr_totals: got writes=%0d grants=%0d, expected writes=10 grants=5",
                     write_cnt - w0, grant_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (grant_log[k] !== 4'(1 << (k % 4))) begin
                    failures++;
                    $display("FAIL rr_grant_%0d: got %b, expected %b", k, grant_log[k], 4'(1 << (k % 4)));
                end
            end
        end
    endtask

    task automatic test_tx_backpressure();
        ch_tx_data[15:8] = 8'hC3;
        ch_tx_valid      = 4'b0010;
        tx_exp.push_back(8'hA1);
        tx_exp.push_back(8'hC3);
        tick();
        ch_tx_valid  = '0;
        uart_tx_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if ({uart_write, uart_tx_data} !== {1'b0, 8'hA1}) begin
                failures++;
                $display("FAIL bp_stall_%0d: got wr=%b data=%h, expected wr=0 data=a1", k, uart_write, uart_tx_data);
            end
            tick();
        end
        uart_tx_full = 1'b0;
        #1;
        checks++;
        if ({uart_write, uart_tx_data} !== {1'b1, 8'hA1}) begin
            failures++;
            $display("FAIL bp_release: got wr=%b data=%h, expected wr=1 data=a1", uart_write, uart_tx_data);
        end
        tick();
        tick();
        checks++;
        if (tx_exp.size() !== 0) begin
            failures++;
            $display("FAIL bp_drain: got pending=%0d, expected 0", tx_exp.size());
        end
    endtask

    task automatic test_rx_demux();
        int budget;
        ch_rx_ready = '0;
        rx_push(8'hA1); rx_push(8'h33); rx_push(8'hA0); rx_push(8'h44);
        rx_exp.push_back('{ch: 1, data: 8'h33});
        rx_exp.push_back('{ch: 0, data: 8'h44});
        tick();
        tick();
        checks++;
        if ({ch_rx_valid, ch_rx_data} !== {4'b0010, 8'h33}) begin
            failures++;
            $display("FAIL demux_out: got valid=%b data=%h, expected valid=0010 data=33", ch_rx_valid, ch_rx_data);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({uart_read, ch_rx_valid} !== {1'b0, 4'b0010}) begin
                failures++;
                $display("FAIL demux_hold_%0d: got rd=%b valid=%b, expected rd=0 valid=0010", k, uart_read, ch_rx_valid);
            end
            tick();
        end
        ch_rx_ready = 4'b1101;
        tick();
        checks++;
        if ({ch_rx_valid, rx_wr - rx_rd} !== {4'b0010, 32'd2}) begin
            failures++;
            $display("FAIL demux_other_ready: got valid=%b fifo=%0d, expected valid=0010 fifo=2",
                     ch_rx_valid, rx_wr - rx_rd);
        end
        ch_rx_ready = 4'b0010;
        tick();
        ch_rx_ready = 4'b1111;
        budget = 0;
        while (rx_exp.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (rx_exp.size() !== 0) begin
            failures++;
            $display("FAIL demux_timeout: got pending=%0d, expected 0", rx_exp.size());
        end
    endtask

    task automatic test_resync();
        int e0;
        int budget;
        ch_rx_ready = 4'b1111;
        e0 = sync_cnt;
        rx_push(8'h12); rx_push(8'hA4); rx_push(8'hA3); rx_push(8'h7E);
        rx_exp.push_back('{ch: 3, data: 8'h7E});
        tick();
        checks++;
        if ({sync_error, err_count} !== {1'b1, 8'd1}) begin
            failures++;
            $display("FAIL resync_first: got se=%b ec=%0d, expected se=1 ec=1", sync_error, err_count);
        end
        tick();
        checks++;
        if ({sync_error, err_count} !== {1'b1, 8'd2}) begin
            failures++;
            $display("FAIL resync_pad_bits: got se=%b ec=%0d, expected se=1 ec=2", sync_error, err_count);
        end
        tick();
        checks++;
        if ({sync_error, err_count} !== {1'b0, 8'd2}) begin
            failures++;
            $display("FAIL resync_valid_hdr: got se=%b ec=%0d, expected se=0 ec=2", sync_error, err_count);
        end
        budget = 0;
        while (rx_exp.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (rx_exp.size() !== 0 || sync_cnt - e0 !== 2) begin
            failures++;
            $display("FAIL resync_deliver: got pending=%0d pulses=%0d, expected pending=0 pulses=2",
                     rx_exp.size(), sync_cnt - e0);
        end
    endtask

    task automatic test_saturation();
        int e0;
        int budget;
        e0 = sync_cnt;
        for (int k = 0; k < 300; k++) rx_push(8'h55);
        budget = 0;
        while (rx_wr != rx_rd && budget < 400) begin
            tick();
            budget++;
        end
        tick();
        tick();
        checks++;
        if ({err_count, sync_cnt - e0} !== {8'd255, 32'd300}) begin
            failures++;
            $display("FAIL saturation: got ec=%0d pulses=%0d, expected ec=255 pulses=300", err_count, sync_cnt - e0);
        end
    endtask

    task automatic test_reset_mid();
        ch_tx_data[31:24] = 8'h99;
        ch_tx_valid       = 4'b1000;
        ch_rx_ready       = '0;
        tx_exp.push_back(8'hA3);
        rx_push(8'hA2);
        rx_push(8'h66);
        tick();
        ch_tx_valid = '0;
        tick();
        checks++;
        if ({uart_write, uart_tx_data, ch_rx_valid, ch_rx_data} !== {1'b1, 8'h99, 4'b0100, 8'h66}) begin
            failures++;
            $display("FAIL mid_setup: got wr=%b tx=%h rxv=%b rxd=%h, expected wr=1 tx=99 rxv=0100 rxd=66",
                     uart_write, uart_tx_data, ch_rx_valid, ch_rx_data);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({uart_tx_data, uart_write, uart_read, ch_tx_ready, ch_rx_data, ch_rx_valid,
             sync_error, err_count} !== 35'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got tx=%h wr=%b rd=%b rdy=%b rxd=%h rxv=%b se=%b ec=%0d, expected all 0",
                     uart_tx_data, uart_write, uart_read, ch_tx_ready, ch_rx_data, ch_rx_valid,
                     sync_error, err_count);
        end
        tick();
        reset = 1'b1;
        tick();
        ch_tx_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        ch_tx_valid = 4'b1111;
        tx_exp.push_back(8'hA0);
        tx_exp.push_back(8'h10);
        #1;
        checks++;
        if (ch_tx_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_next_grant: got %b, expected 0001", ch_tx_ready);
        end
        tick();
        ch_tx_valid = '0;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (tx_exp.size() !== 0 || rx_exp.size() !== 0) begin
            failures++;
            $display("FAIL final_drain: got tx_pending=%0d rx_pending=%0d, expected 0 and 0",
                     tx_exp.size(), rx_exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_tx_backpressure();
        test_rx_demux();
        test_resync();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
